// File: rtl/io_bus_arbiter_pkg.sv
// Shared IO bus definitions: mode codes, payload struct, arbiter FSM states and
// the write-classification helper used by io_bus_arbiter.
package io_bus_arbiter_pkg;

   localparam int unsigned IO_MODE_W = 4;
   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned CNT_W     = 4;

   localparam logic [IO_MODE_W-1:0] IO_NOP = 4'h0;
   localparam logic [IO_MODE_W-1:0] IO_LB  = 4'h1;
   localparam logic [IO_MODE_W-1:0] IO_LH  = 4'h2;
   localparam logic [IO_MODE_W-1:0] IO_LW  = 4'h3;
   localparam logic [IO_MODE_W-1:0] IO_LBU = 4'h4;
   localparam logic [IO_MODE_W-1:0] IO_LHU = 4'h5;
   localparam logic [IO_MODE_W-1:0] IO_SB  = 4'h9;
   localparam logic [IO_MODE_W-1:0] IO_SH  = 4'hA;
   localparam logic [IO_MODE_W-1:0] IO_SW  = 4'hB;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_RESP   = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [IO_MODE_W-1:0] mode;
      logic [ADDR_W-1:0]    addr;
      logic [DATA_W-1:0]    wdata;
   } io_req_t;

   function automatic logic io_is_write(input logic [IO_MODE_W-1:0] mode);
      return (mode == IO_SB) || (mode == IO_SH) || (mode == IO_SW);
   endfunction

endpackage

// File: rtl/io_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester wins, on a tie the
// requester that was not granted last wins.
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic       valid_c_o,
   output logic       winner_c_o
);

   always_comb begin
      valid_c_o  = |req_i;
      winner_c_o = (req_i == 2'b11) ? ~last_grant_i : req_i[1];
   end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares one IO/memory slave port between M0 (CPU) and M1 (DMA/boot loader):
// round-robin grant, latched request held for WAIT_CYCLES+1 cycles, one-cycle ready.
module io_bus_arbiter
   import io_bus_arbiter_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter bit          RESET_LAST  = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IO_MODE_W-1:0] m0_mode,
   input  logic [ADDR_W-1:0]    m0_addr,
   input  logic [DATA_W-1:0]    m0_wdata,
   output logic [DATA_W-1:0]    m0_rdata,
   output logic                 m0_ready,
   input  logic [IO_MODE_W-1:0] m1_mode,
   input  logic [ADDR_W-1:0]    m1_addr,
   input  logic [DATA_W-1:0]    m1_wdata,
   output logic [DATA_W-1:0]    m1_rdata,
   output logic                 m1_ready,
   output logic [IO_MODE_W-1:0] s_mode,
   output logic [ADDR_W-1:0]    s_addr,
   output logic [DATA_W-1:0]    s_wdata,
   input  logic [DATA_W-1:0]    s_rdata,
   output logic                 grant,
   output logic                 busy
);

   arb_state_e        state_q, state_d;
   io_req_t           slv_q, slv_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_grant_q, last_grant_d;
   logic              grant_q, grant_d;
   logic              busy_q, busy_d;
   logic [1:0]        ready_q, ready_d;
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

   logic [1:0]        req_c;
   logic              win_valid_c;
   logic              win_c;
   io_req_t           m0_req_c, m1_req_c;

   assign req_c    = {m1_mode != IO_NOP, m0_mode != IO_NOP};
   assign m0_req_c = '{mode: m0_mode, addr: m0_addr, wdata: m0_wdata};
   assign m1_req_c = '{mode: m1_mode, addr: m1_addr, wdata: m1_wdata};

   rr_arb2 u_rr_arb2 (
      .req_i        (req_c),
      .last_grant_i (last_grant_q),
      .valid_c_o    (win_valid_c),
      .winner_c_o   (win_c)
   );

   // Next-state and registered-output logic; the slave register doubles as the latched request.
   always_comb begin
      state_d      = state_q;
      slv_d        = slv_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      busy_d       = busy_q;
      ready_d      = 2'b00;
      m0_rdata_d   = m0_rdata_q;
      m1_rdata_d   = m1_rdata_q;

      unique case (state_q)
         ARB_IDLE: begin
            if (win_valid_c) begin
               slv_d        = win_c ? m1_req_c : m0_req_c;
               cnt_d        = CNT_W'(WAIT_CYCLES);
               grant_d      = win_c;
               last_grant_d = win_c;
               busy_d       = 1'b1;
               state_d      = ARB_ACCESS;
            end
         end
         ARB_ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               if (!io_is_write(slv_q.mode)) begin
                  if (grant_q) m1_rdata_d = s_rdata;
                  else         m0_rdata_d = s_rdata;
               end
               ready_d    = grant_q ? 2'b10 : 2'b01;
               slv_d.mode = IO_NOP;
               state_d    = ARB_RESP;
            end
         end
         ARB_RESP: begin
            busy_d  = 1'b0;
            state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         slv_q        <= '{mode: IO_NOP, addr: '0, wdata: '0};
         cnt_q        <= '0;
         last_grant_q <= RESET_LAST;
         grant_q      <= 1'b0;
         busy_q       <= 1'b0;
         ready_q      <= 2'b00;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         slv_q        <= slv_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         busy_q       <= busy_d;
         ready_q      <= ready_d;
         m0_rdata_q   <= m0_rdata_d;
         m1_rdata_q   <= m1_rdata_d;
      end
   end

   assign s_mode   = slv_q.mode;
   assign s_addr   = slv_q.addr;
   assign s_wdata  = slv_q.wdata;
   assign m0_ready = ready_q[0];
   assign m1_ready = ready_q[1];
   assign m0_rdata = m0_rdata_q;
   assign m1_rdata = m1_rdata_q;
   assign grant    = grant_q;
   assign busy     = busy_q;

endmodule
